// File: rtl/ask_defs.sv
// Shared definitions for the ASK framer/modulator/demodulator path.
// State encodings, frame bit values and the carrier word width.
package ask_defs;

    localparam int ASK_FREQ_W    = 6;
    localparam int ASK_DATA_BITS = 8;

    localparam logic ASK_START_BIT = 1'b1;
    localparam logic ASK_STOP_BIT  = 1'b0;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_PREAMBLE = ST_PREAMBLE,
        S_START    = ST_START,
        S_DATA     = ST_DATA,
        S_STOP     = ST_STOP
    } ask_state_t;

endpackage

// File: rtl/ask_bit_timer.sv
// Bit-period down-counter; o_tick marks the last cycle of each bit.
// Held at the top count while i_clear is high.
module ask_bit_timer #(
    parameter int CLKS_PER_BIT = 500
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= TOP;
        end else if (i_clear || cnt == '0) begin
            cnt <= TOP;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_tick = !i_clear && (cnt == '0);

endmodule

// File: rtl/ask_bit_framer.sv
// Byte-to-OOK framer: preamble, start, 8 data bits LSB first, stop.
// Carrier word is latched at accept so it never changes mid-frame.
module ask_bit_framer
    import ask_defs::*;
#(
    parameter int CLKS_PER_BIT  = 500,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_byte,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ASK_FREQ_W-1:0] i_freq_sel,
    output logic [ASK_FREQ_W-1:0] o_freq_word,
    output logic                  o_data,
    output logic                  o_busy,
    output logic                  o_bit_strobe,
    output logic                  o_clk_en
);

    localparam logic [3:0] PRE_LAST  = 4'(PREAMBLE_BITS - 1);
    localparam logic [3:0] DATA_LAST = 4'(ASK_DATA_BITS - 1);

    ask_state_t state;
    logic [7:0] shreg;
    logic [3:0] bit_cnt;
    logic       tick;

    ask_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clear(state == S_IDLE),
        .o_tick (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            o_data       <= 1'b0;
            o_freq_word  <= '0;
            o_busy       <= 1'b0;
            o_bit_strobe <= 1'b0;
            o_clk_en     <= 1'b0;
            o_ready      <= 1'b0;
        end else begin
            o_clk_en     <= 1'b1;
            o_bit_strobe <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    o_data  <= 1'b0;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        shreg        <= i_byte;
                        o_freq_word  <= i_freq_sel;
                        o_ready      <= 1'b0;
                        o_busy       <= 1'b1;
                        o_bit_strobe <= 1'b1;
                        bit_cnt      <= '0;
                        if (PREAMBLE_BITS == 0) begin
                            state  <= S_START;
                            o_data <= ASK_START_BIT;
                        end else begin
                            state  <= S_PREAMBLE;
                            o_data <= 1'b1;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (tick) begin
                        o_bit_strobe <= 1'b1;
                        if (bit_cnt == PRE_LAST) begin
                            state   <= S_START;
                            o_data  <= ASK_START_BIT;
                            bit_cnt <= '0;
                        end else begin
                            // next bit index is odd exactly when the current one is even
                            bit_cnt <= bit_cnt + 1'b1;
                            o_data  <= bit_cnt[0];
                        end
                    end
                end
                S_START: begin
                    if (tick) begin
                        o_bit_strobe <= 1'b1;
                        state        <= S_DATA;
                        o_data       <= shreg[0];
                        bit_cnt      <= '0;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        o_bit_strobe <= 1'b1;
                        if (bit_cnt == DATA_LAST) begin
                            state  <= S_STOP;
                            o_data <= ASK_STOP_BIT;
                        end else begin
                            shreg   <= shreg >> 1;
                            o_data  <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        state   <= S_IDLE;
                        o_data  <= 1'b0;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ask_bit_framer.sv
// Directed and randomized checks of ask_bit_framer against a frame model.
// Two builds: 4 clocks/bit with 4 preamble bits, and 1 clock/bit without preamble.
module tb_ask_bit_framer;

    localparam int C    = 4;
    localparam int P    = 4;
    localparam int FLEN = (P + 10) * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         acc_cyc = 0;
    int         prev_acc = 0;

    logic [7:0] i_byte = '0;
    logic       i_valid = 1'b0;
    logic [5:0] i_freq_sel = '0;
    logic       o_ready, o_data, o_busy, o_bit_strobe, o_clk_en;
    logic [5:0] o_freq_word;

    logic [7:0] f_byte = '0;
    logic       f_valid = 1'b0;
    logic [5:0] f_sel = '0;
    logic       f_ready, f_data, f_busy, f_strobe, f_clk_en;
    logic [5:0] f_freq;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ask_bit_framer #(.CLKS_PER_BIT(C), .PREAMBLE_BITS(P)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_byte(i_byte), .i_valid(i_valid), .o_ready(o_ready),
        .i_freq_sel(i_freq_sel), .o_freq_word(o_freq_word),
        .o_data(o_data), .o_busy(o_busy),
        .o_bit_strobe(o_bit_strobe), .o_clk_en(o_clk_en)
    );

    ask_bit_framer #(.CLKS_PER_BIT(1), .PREAMBLE_BITS(0)) u_fast (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_byte(f_byte), .i_valid(f_valid), .o_ready(f_ready),
        .i_freq_sel(f_sel), .o_freq_word(f_freq),
        .o_data(f_data), .o_busy(f_busy),
        .o_bit_strobe(f_strobe), .o_clk_en(f_clk_en)
    );

    // Frame bit idx: preamble 1,0,1..., start 1, data LSB first, stop 0.
    function automatic logic exp_bit(input logic [7:0] b, input int pre, input int idx);
        if (idx < pre) return (idx % 2) == 0;
        if (idx == pre) return 1'b1;
        if (idx <= pre + 8) return b[idx - pre - 1];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] b, input logic [5:0] f);
        int n;
        i_byte = b;
        i_freq_sel = f;
        i_valid = 1'b1;
        n = 0;
        while (o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(o_ready), 32'd1);
        prev_acc = acc_cyc;
        acc_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic check_frame(input logic [7:0] b, input logic [5:0] f, input bit hold,
                               input logic [7:0] nb, input int chg_at, input int stop_at);
        int strobes;
        strobes = 0;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (hold) i_byte = nb;
                else i_valid = 1'b0;
            end
            chk("data", 32'(o_data), 32'(exp_bit(b, P, k / C)));
            chk("strobe", 32'(o_bit_strobe), 32'((k % C) == 0));
            chk("busy", 32'(o_busy), 32'd1);
            chk("ready_busy", 32'(o_ready), 32'd0);
            chk("freq_word", 32'(o_freq_word), 32'(f));
            strobes += int'(o_bit_strobe);
            if (k == chg_at) i_freq_sel = 6'd40;
            if (k == stop_at) return;
        end
        chk("strobe_count", 32'(strobes), 32'(P + 10));
        @(negedge clk);
        chk("idle_ready", 32'(o_ready), 32'd1);
        chk("idle_data", 32'(o_data), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_strobe", 32'(o_bit_strobe), 32'd0);
    endtask

    task automatic fast_frame(input logic [7:0] b);
        int n;
        f_byte = b;
        f_sel = 6'(b);
        f_valid = 1'b1;
        n = 0;
        while (f_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("f_ready_wait", 32'(f_ready), 32'd1);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) f_valid = 1'b0;
            chk("f_data", 32'(f_data), 32'(exp_bit(b, 0, k)));
            chk("f_strobe", 32'(f_strobe), 32'd1);
            chk("f_busy", 32'(f_busy), 32'd1);
            chk("f_freq", 32'(f_freq), 32'(6'(b)));
        end
        @(negedge clk);
        chk("f_idle_data", 32'(f_data), 32'd0);
        chk("f_idle_strobe", 32'(f_strobe), 32'd0);
        chk("f_idle_ready", 32'(f_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] rb;
        logic [5:0] rf;

        // reset held for 5 cycles
        repeat (5) begin
            @(negedge clk);
            chk("rst_data", 32'(o_data), 32'd0);
            chk("rst_ready", 32'(o_ready), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_strobe", 32'(o_bit_strobe), 32'd0);
            chk("rst_clk_en", 32'(o_clk_en), 32'd0);
            chk("rst_freq", 32'(o_freq_word), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_clk_en", 32'(o_clk_en), 32'd1);
        chk("post_rst_ready", 32'(o_ready), 32'd1);
        chk("post_rst_data", 32'(o_data), 32'd0);
        chk("f_post_rst_clk_en", 32'(f_clk_en), 32'd1);

        // 0xA5 at word 10, with the select moved to 40 mid-frame
        start_frame(8'hA5, 6'd10);
        check_frame(8'hA5, 6'd10, 1'b0, 8'h00, 20, -1);

        rb = 8'($urandom);
        start_frame(rb, 6'd40);
        check_frame(rb, 6'd40, 1'b0, 8'h00, -1, -1);

        // back-to-back with valid held high
        start_frame(8'h00, 6'd40);
        check_frame(8'h00, 6'd40, 1'b1, 8'hFF, -1, -1);
        start_frame(8'hFF, 6'd40);
        chk("b2b_gap", 32'(acc_cyc - prev_acc), 32'(FLEN + 1));

        // reset during the third data bit of 0xFF
        check_frame(8'hFF, 6'd40, 1'b0, 8'h00, -1, (P + 3) * C + 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(o_data), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        chk("async_rst_ready", 32'(o_ready), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("in_rst_strobe", 32'(o_bit_strobe), 32'd0);
            chk("in_rst_data", 32'(o_data), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerst_ready", 32'(o_ready), 32'd1);
        chk("rerst_busy", 32'(o_busy), 32'd0);
        chk("rerst_clk_en", 32'(o_clk_en), 32'd1);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            rf = 6'($urandom_range(0, 63));
            start_frame(rb, rf);
            check_frame(rb, rf, 1'b0, 8'h00, $urandom_range(1, FLEN - 1), -1);
        end

        // single clock per bit, no preamble
        fast_frame(8'h01);
        fast_frame(8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
